// File: rtl/usb_rx_packetizer_pkg.sv
// Shared types and constants for the low-speed USB receive packetizer.
package usb_rx_packetizer_pkg;

  // Retimed line state from the CDR, encoded as {D+, D-}.
  // Low-speed J is D- high; K is D+ high.
  typedef enum logic [1:0] {
    D_SE0 = 2'b00,
    D_J   = 2'b01,
    D_K   = 2'b10,
    D_SE1 = 2'b11
  } d_port_t;

  typedef enum logic [1:0] {
    ERR_SYNC  = 2'd0,
    ERR_STUFF = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_LINE  = 2'd3
  } rx_err_t;

  // Receiver states kept as plain constants so older tools can consume them.
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_SYNC  = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_EOP   = 3'd3;
  localparam rx_state_t ST_ERROR = 3'd4;

  // Six consecutive ones force a stuffed zero.
  localparam int unsigned STUFF_LIMIT    = 6;
  // A full SYNC carries seven zeros; more than that is not a SYNC.
  localparam int unsigned SYNC_MAX_ZEROS = 7;

  // True for the two differential data levels.
  function automatic logic is_jk(input d_port_t v);
    return (v == D_J) || (v == D_K);
  endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit-unstuffer. Tracks the previous differential level and
// the current run of decoded ones, and flags which data bits are real.
module usb_nrzi_unstuff
  import usb_rx_packetizer_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    strobe_i,
  input  d_port_t d_i,
  input  logic    clear_i,
  input  logic    data_en_i,
  output logic    bit_o,
  output logic    bit_valid_o,
  output logic    stuff_err_o
);

  d_port_t    prev_q, prev_d;
  logic [2:0] ones_q, ones_d;
  logic       line_jk;
  logic       stuff_slot;

  // Decode the current level and classify it as data, stuffed bit or violation.
  always_comb begin
    line_jk     = is_jk(d_i);
    bit_o       = (d_i == prev_q);
    stuff_slot  = (ones_q == 3'(STUFF_LIMIT));
    bit_valid_o = strobe_i & data_en_i & line_jk & ~stuff_slot;
    stuff_err_o = strobe_i & data_en_i & line_jk & stuff_slot & bit_o;
  end

  // Next previous-level and ones-run; the SYNC's closing one seeds the run at 1.
  always_comb begin
    prev_d = prev_q;
    ones_d = ones_q;
    if (strobe_i) begin
      if (line_jk) begin
        prev_d = d_i;
      end
      if (clear_i) begin
        ones_d = 3'd1;
      end else if (data_en_i && line_jk) begin
        if (stuff_slot) begin
          ones_d = 3'd0;
        end else if (bit_o) begin
          ones_d = ones_q + 3'd1;
        end else begin
          ones_d = 3'd0;
        end
      end
    end
  end

  // State registers; the line idles in J.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= D_J;
      ones_q <= 3'd0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_packetizer.sv
// Low-speed USB receive packetizer: SYNC detection, NRZI decode with
// unstuffing, LSB-first byte assembly and EOP/error reporting.
//
// state    | meaning
// ST_IDLE  | bus idle, waiting for the first K of SYNC
// ST_SYNC  | counting SYNC zeros, waiting for the closing one
// ST_DATA  | assembling data bytes
// ST_EOP   | SE0 seen, waiting for the J that closes the packet
// ST_ERROR | receive error, waiting for a run of idle J
module usb_rx_packetizer
  import usb_rx_packetizer_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = 4,
  parameter int unsigned IDLE_J_COUNT   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  d_port_t    d,
  input  logic       strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error,
  output rx_err_t    rx_err_code
);

  localparam int unsigned JW = $clog2(IDLE_J_COUNT + 1);

  rx_state_t  state_q, state_d;
  logic [2:0] zero_q, zero_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] se0_q, se0_d;
  logic [JW-1:0] jcnt_q, jcnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       eop_q, eop_d;
  logic       error_q, error_d;
  rx_err_t    err_code_q, err_code_d;

  logic       dec_bit;
  logic       bit_valid;
  logic       stuff_err;
  logic       sync_done;
  logic       raise_err;
  rx_err_t    err_sel;

  usb_nrzi_unstuff u_nrzi_unstuff (
    .clk        (clk),
    .reset      (reset),
    .strobe_i   (strobe),
    .d_i        (d),
    .clear_i    (sync_done),
    .data_en_i  (state_q == ST_DATA),
    .bit_o      (dec_bit),
    .bit_valid_o(bit_valid),
    .stuff_err_o(stuff_err)
  );

  // Receive FSM: every transition happens on a strobe; pulses default low.
  always_comb begin
    state_d    = state_q;
    zero_d     = zero_q;
    bit_cnt_d  = bit_cnt_q;
    se0_d      = se0_q;
    jcnt_d     = jcnt_q;
    data_d     = data_q;
    active_d   = active_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    eop_d      = 1'b0;
    error_d    = 1'b0;
    sync_done  = 1'b0;
    raise_err  = 1'b0;
    err_sel    = ERR_SYNC;

    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (d == D_K) begin
            state_d = ST_SYNC;
            zero_d  = 3'd1;
          end
        end

        ST_SYNC: begin
          if (!is_jk(d)) begin
            raise_err = 1'b1;
            err_sel   = ERR_SYNC;
          end else if (!dec_bit) begin
            if (zero_q == 3'(SYNC_MAX_ZEROS)) begin
              raise_err = 1'b1;
              err_sel   = ERR_SYNC;
            end else begin
              zero_d = zero_q + 3'd1;
            end
          end else if (zero_q >= 3'(SYNC_MIN_ZEROS)) begin
            state_d   = ST_DATA;
            active_d  = 1'b1;
            bit_cnt_d = 3'd0;
            sync_done = 1'b1;
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_SYNC;
          end
        end

        ST_DATA: begin
          if (d == D_SE0) begin
            state_d = ST_EOP;
            se0_d   = 2'd1;
          end else if (d == D_SE1) begin
            raise_err = 1'b1;
            err_sel   = ERR_LINE;
          end else if (stuff_err) begin
            raise_err = 1'b1;
            err_sel   = ERR_STUFF;
          end else if (bit_valid) begin
            data_d    = {dec_bit, data_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            valid_d   = (bit_cnt_q == 3'd7);
          end
        end

        ST_EOP: begin
          case (d)
            D_SE0: begin
              if (se0_q == 2'd2) begin
                raise_err = 1'b1;
                err_sel   = ERR_LINE;
              end else begin
                se0_d = se0_q + 2'd1;
              end
            end
            D_J: begin
              if (bit_cnt_q == 3'd0) begin
                eop_d    = 1'b1;
                active_d = 1'b0;
                state_d  = ST_IDLE;
              end else begin
                raise_err = 1'b1;
                err_sel   = ERR_ALIGN;
              end
            end
            default: begin
              raise_err = 1'b1;
              err_sel   = ERR_LINE;
            end
          endcase
        end

        ST_ERROR: begin
          if (d == D_J) begin
            if (jcnt_q == JW'(IDLE_J_COUNT - 1)) begin
              state_d = ST_IDLE;
              jcnt_d  = '0;
            end else begin
              jcnt_d = jcnt_q + 1'b1;
            end
          end else begin
            jcnt_d = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase

      // A misaligned EOP still ends on idle J, so it returns straight to IDLE.
      if (raise_err) begin
        error_d    = 1'b1;
        err_code_d = err_sel;
        active_d   = 1'b0;
        jcnt_d     = '0;
        state_d    = (err_sel == ERR_ALIGN) ? ST_IDLE : ST_ERROR;
      end
    end
  end

  // FSM, counters, shift register and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      zero_q     <= 3'd0;
      bit_cnt_q  <= 3'd0;
      se0_q      <= 2'd0;
      jcnt_q     <= '0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      eop_q      <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_SYNC;
    end else begin
      state_q    <= state_d;
      zero_q     <= zero_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_q      <= se0_d;
      jcnt_q     <= jcnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      eop_q      <= eop_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_active   = active_q;
  assign rx_eop      = eop_q;
  assign rx_error    = error_q;
  assign rx_err_code = err_code_q;

endmodule

// File: tb/tb_usb_rx_packetizer.sv
// Scoreboard bench for usb_rx_packetizer: expected events are queued as
// packets are sent; a monitor pops one per output pulse.
module tb_usb_rx_packetizer;
  import usb_rx_packetizer_pkg::*;

  localparam int K_VALID = 0;
  localparam int K_EOP   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] val;
    logic       active;
  } exp_t;

  logic       clk;
  logic       reset;
  d_port_t    d;
  logic       strobe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;
  rx_err_t    rx_err_code;

  exp_t exp_q[$];
  int   total;
  int   bad;

  usb_rx_packetizer #(
    .SYNC_MIN_ZEROS(4),
    .IDLE_J_COUNT  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .strobe     (strobe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .rx_eop     (rx_eop),
    .rx_error   (rx_error),
    .rx_err_code(rx_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int kind, input logic [7:0] val, input logic active);
    exp_t e;
    e.kind   = kind;
    e.val    = val;
    e.active = active;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  function automatic d_port_t c2d(input byte c);
    case (c)
      "J":     return D_J;
      "K":     return D_K;
      "0":     return D_SE0;
      default: return D_SE1;
    endcase
  endfunction

  // One strobe carrying level v; consecutive strobes are gap clocks apart.
  task automatic sym(input d_port_t v, input int gap);
    @(negedge clk);
    d = v;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send(input string s, input bit jitter);
    for (int i = 0; i < s.len(); i++) begin
      sym(c2d(s[i]), jitter ? 15 + (i % 3) : 16);
    end
  endtask

  task automatic monitor_loop();
    exp_t       e;
    int         kind;
    logic [7:0] val;
    forever begin
      @(negedge clk);
      if (reset && (rx_valid || rx_eop || rx_error)) begin
        if (int'(rx_valid) + int'(rx_eop) + int'(rx_error) > 1) begin
          total++;
          bad++;
          $display("FAIL pulse_overlap valid=%0b eop=%0b error=%0b", rx_valid, rx_eop, rx_error);
        end else begin
          kind = rx_valid ? K_VALID : (rx_eop ? K_EOP : K_ERR);
          val  = rx_valid ? rx_data : (rx_error ? {6'd0, rx_err_code} : 8'd0);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d val=%0h active=%0b want none",
                     kind, val, rx_active);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.active != rx_active) begin
              bad++;
              $display("FAIL event got kind=%0d val=%0h active=%0b want kind=%0d val=%0h active=%0b",
                       kind, val, rx_active, e.kind, e.val, e.active);
            end
          end
        end
      end
    end
  endtask

  localparam string SYNC7 = "KJKJKJKK";
  localparam string A5    = "KJJKJJKK";

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    d      = D_J;
    strobe = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_flags", {28'd0, rx_valid, rx_active, rx_eop, rx_error}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_code", {30'd0, rx_err_code}, {30'd0, ERR_SYNC});
    @(negedge clk);
    reset = 1'b1;

    // Clean 0xA5 packet with full SYNC.
    push(K_VALID, 8'hA5, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({"JJJ", SYNC7, A5, "00J"}, 1'b0);

    // 0xFF with a stuffed zero after the fifth one.
    push(K_VALID, 8'hFF, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({"JJ", SYNC7, "KKKKKJJJJ", "00J"}, 1'b0);

    // Missing stuffed bit; seven J then K must not recover, eight J must.
    push(K_ERR, 8'(ERR_STUFF), 1'b0);
    send({SYNC7, "KKKKKK"}, 1'b0);
    send("JJJJJJJKJJJJJJJJ", 1'b0);
    push(K_VALID, 8'hA5, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({SYNC7, A5, "00J"}, 1'b0);

    // Three SYNC zeros rejected, eight zeros rejected, four zeros accepted.
    push(K_ERR, 8'(ERR_SYNC), 1'b0);
    send({"JJ", "KJKK", "JJJJJJJJ"}, 1'b0);
    push(K_ERR, 8'(ERR_SYNC), 1'b0);
    send({"KJKJKJKJ", "JJJJJJJJ"}, 1'b0);
    push(K_VALID, 8'h3C, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({"KJKJJ", "KJJJJJKJ", "00J"}, 1'b0);

    // Misaligned EOP returns straight to IDLE: next packet needs no idle run.
    push(K_ERR, 8'(ERR_ALIGN), 1'b0);
    send({"JJ", SYNC7, "KJJKJ", "00J"}, 1'b0);
    push(K_VALID, 8'hA5, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({SYNC7, A5, "00J"}, 1'b0);

    // Over-long SE0 and SE1 in data are line errors.
    push(K_ERR, 8'(ERR_LINE), 1'b0);
    send({"JJ", SYNC7, "KJJ", "0000", "JJJJJJJJ"}, 1'b0);
    push(K_ERR, 8'(ERR_LINE), 1'b0);
    send({SYNC7, "KJ", "1", "JJJJJJJJ"}, 1'b0);

    // Asynchronous reset mid-byte drops the partial byte.
    send({"JJ", SYNC7, "KJJ"}, 1'b0);
    chk("active_before_reset", {31'd0, rx_active}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_flags", {28'd0, rx_valid, rx_active, rx_eop, rx_error}, 32'd0);
    chk("async_reset_data", {24'd0, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    chk("held_reset_code", {30'd0, rx_err_code}, {30'd0, ERR_SYNC});
    d = D_J;
    reset = 1'b1;

    // Packet with 15/16/17-clock strobe spacing.
    push(K_VALID, 8'hA5, 1'b1);
    push(K_EOP, 8'h00, 1'b0);
    send({"JJ", SYNC7, A5, "00J"}, 1'b1);

    repeat (50) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
